// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the decode-stage operand hazard unit.
package hazard_scoreboard_pkg;

    // Register address that is hardwired to zero and never forwarded.
    localparam int ZERO_REG = 0;

    // Forward-select encoding for "take the register-file read".
    localparam int FWD_RF = 0;

endpackage

// File: rtl/hazard_scoreboard_fwd_operand_sel.sv
// Per-operand forwarding search: finds the youngest in-flight producer of one
// source register and reports its slot, its data and whether that data is late.
module fwd_operand_sel
    import hazard_scoreboard_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic [ADDR_W-1:0]             addr,
    input  logic                          use_en,
    input  logic [DEPTH-1:0]              slot_valid,
    input  logic [DEPTH-1:0]              slot_we,
    input  logic [DEPTH-1:0]              slot_is_load,
    input  logic [DEPTH-1:0][ADDR_W-1:0]  slot_waddr,
    input  logic [DEPTH*DATA_W-1:0]       stage_data,
    input  logic [DATA_W-1:0]             rf_data,
    output logic [SEL_W-1:0]              sel,
    output logic [DATA_W-1:0]             data,
    output logic                          hazard
);

    logic found;

    // Priority search from slot 0 upward so the youngest producer wins.
    always_comb begin
        sel    = SEL_W'(FWD_RF);
        data   = rf_data;
        hazard = 1'b0;
        found  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && use_en && slot_valid[k] && slot_we[k] &&
                slot_waddr[k] == addr && addr != ADDR_W'(ZERO_REG)) begin
                found  = 1'b1;
                sel    = SEL_W'(k + 1);
                data   = stage_data[k*DATA_W +: DATA_W];
                // A load has no data before LOAD_STAGE; the ALU result is always there.
                hazard = slot_is_load[k] && (k < LOAD_STAGE);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage operand hazard unit: shift-register scoreboard of in-flight
// destinations, rs/rt forwarding, load-use stall and a saturating stall counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hold,
    input  logic                        flush,
    input  logic                        id_valid,
    input  logic [ADDR_W-1:0]           id_rs_addr,
    input  logic [ADDR_W-1:0]           id_rt_addr,
    input  logic                        id_use_rs,
    input  logic                        id_use_rt,
    input  logic                        id_we,
    input  logic [ADDR_W-1:0]           id_waddr,
    input  logic                        id_is_load,
    input  logic [DEPTH*DATA_W-1:0]     stage_data,
    input  logic [DATA_W-1:0]           rf_rs_data,
    input  logic [DATA_W-1:0]           rf_rt_data,
    output logic [DATA_W-1:0]           rs_data,
    output logic [DATA_W-1:0]           rt_data,
    output logic [$clog2(DEPTH+1)-1:0]  rs_fwd_sel,
    output logic [$clog2(DEPTH+1)-1:0]  rt_fwd_sel,
    output logic                        stall,
    output logic [CNT_W-1:0]            stall_count
);

    localparam int SEL_W = $clog2(DEPTH + 1);

    // Scoreboard slots: index 0 is EX, DEPTH-1 is WB.
    logic [DEPTH-1:0]             slot_valid;
    logic [DEPTH-1:0]             slot_we;
    logic [DEPTH-1:0]             slot_is_load;
    logic [DEPTH-1:0][ADDR_W-1:0] slot_waddr;

    logic rs_hazard;
    logic rt_hazard;
    logic issue;

    fwd_operand_sel #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
    ) u_rs_sel (
        .addr        (id_rs_addr),
        .use_en      (id_use_rs),
        .slot_valid  (slot_valid),
        .slot_we     (slot_we),
        .slot_is_load(slot_is_load),
        .slot_waddr  (slot_waddr),
        .stage_data  (stage_data),
        .rf_data     (rf_rs_data),
        .sel         (rs_fwd_sel),
        .data        (rs_data),
        .hazard      (rs_hazard)
    );

    fwd_operand_sel #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
    ) u_rt_sel (
        .addr        (id_rt_addr),
        .use_en      (id_use_rt),
        .slot_valid  (slot_valid),
        .slot_we     (slot_we),
        .slot_is_load(slot_is_load),
        .slot_waddr  (slot_waddr),
        .stage_data  (stage_data),
        .rf_data     (rf_rt_data),
        .sel         (rt_fwd_sel),
        .data        (rt_data),
        .hazard      (rt_hazard)
    );

    // Stall only for a live, unflushed instruction; flush always wins over a hazard.
    always_comb begin
        stall = id_valid && !flush && (rs_hazard || rt_hazard);
        issue = id_valid && !flush && !stall;
    end

    // Slot shift register: advance one stage per unfrozen cycle, bubble on stall/flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid   <= '0;
            slot_we      <= '0;
            slot_is_load <= '0;
            slot_waddr   <= '0;
        end else if (!hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                slot_valid[k]   <= slot_valid[k-1];
                slot_we[k]      <= slot_we[k-1];
                slot_is_load[k] <= slot_is_load[k-1];
                slot_waddr[k]   <= slot_waddr[k-1];
            end
            slot_valid[0]   <= issue;
            slot_we[0]      <= issue && id_we;
            slot_is_load[0] <= issue && id_is_load;
            slot_waddr[0]   <= issue ? id_waddr : '0;
        end
    end

    // Saturating stall-cycle counter; frozen cycles are not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (stall && !hold && stall_count != {CNT_W{1'b1}})
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: stimulus computes expected outputs from a queue-based model
// of in-flight instructions; a negedge monitor pops and compares.
module tb_hazard_scoreboard;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int DEPTH      = 3;
    localparam int LOAD_STAGE = 1;
    localparam int CNT_W      = 4;
    localparam int SEL_W      = $clog2(DEPTH + 1);

    logic                      clk = 0;
    logic                      rst = 1;
    logic                      hold = 0, flush = 0, id_valid = 0;
    logic [ADDR_W-1:0]         id_rs_addr = 0, id_rt_addr = 0, id_waddr = 0;
    logic                      id_use_rs = 0, id_use_rt = 0, id_we = 0, id_is_load = 0;
    logic [DEPTH*DATA_W-1:0]   stage_data = 0;
    logic [DATA_W-1:0]         rf_rs_data = 0, rf_rt_data = 0;
    logic [DATA_W-1:0]         rs_data, rt_data;
    logic [SEL_W-1:0]          rs_fwd_sel, rt_fwd_sel;
    logic                      stall;
    logic [CNT_W-1:0]          stall_count;

    hazard_scoreboard #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .LOAD_STAGE(LOAD_STAGE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_we(id_we), .id_waddr(id_waddr), .id_is_load(id_is_load),
        .stage_data(stage_data), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
        .rs_data(rs_data), .rt_data(rt_data),
        .rs_fwd_sel(rs_fwd_sel), .rt_fwd_sel(rt_fwd_sel),
        .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Model: in-flight instructions, front = EX, back = WB.
    typedef struct {bit valid; bit we; bit is_load; int waddr;} ent_t;
    typedef struct {bit stall; int rs_sel; int rt_sel;
                    logic [DATA_W-1:0] rs_d; logic [DATA_W-1:0] rt_d; int cnt;} exp_t;

    ent_t pipe[$];
    exp_t expq[$];
    int   mcount = 0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    function automatic void model_clear();
        ent_t b;
        b.valid = 0; b.we = 0; b.is_load = 0; b.waddr = 0;
        pipe.delete();
        for (int i = 0; i < DEPTH; i++) pipe.push_back(b);
        mcount = 0;
    endfunction

    // Youngest in-flight writer of addr; late if it is a load still before LOAD_STAGE.
    function automatic void resolve(input int addr, input bit use_op,
                                    input logic [DATA_W-1:0] rf,
                                    output int sel, output logic [DATA_W-1:0] d,
                                    output bit late);
        sel = 0; d = rf; late = 0;
        if (!use_op || addr == 0) return;
        foreach (pipe[i]) begin
            if (pipe[i].valid && pipe[i].we && pipe[i].waddr == addr) begin
                sel  = i + 1;
                d    = stage_data[i*DATA_W +: DATA_W];
                late = pipe[i].is_load && (i < LOAD_STAGE);
                return;
            end
        end
    endfunction

    // One decode cycle: drive, predict, (optionally reset mid-cycle), advance model.
    task automatic step(input bit v, input bit fl, input bit hd,
                        input bit urs, input int rs, input bit urt, input int rt,
                        input bit we, input int wa, input bit ld, input bit rmid);
        exp_t e;
        bit   lrs, lrt;
        ent_t n;
        rst = 0;
        id_valid = v; flush = fl; hold = hd;
        id_use_rs = urs; id_rs_addr = ADDR_W'(rs);
        id_use_rt = urt; id_rt_addr = ADDR_W'(rt);
        id_we = we; id_waddr = ADDR_W'(wa); id_is_load = ld;
        for (int k = 0; k < DEPTH; k++) stage_data[k*DATA_W +: DATA_W] = $urandom;
        rf_rs_data = $urandom;
        rf_rt_data = $urandom;
        if (rmid) begin
            #1 rst = 1;
            model_clear();
        end
        resolve(rs, urs, rf_rs_data, e.rs_sel, e.rs_d, lrs);
        resolve(rt, urt, rf_rt_data, e.rt_sel, e.rt_d, lrt);
        e.stall = v && !fl && (lrs || lrt);
        e.cnt   = mcount;
        expq.push_back(e);
        @(posedge clk);
        if (!rmid && !hd) begin
            if (e.stall && mcount < (1 << CNT_W) - 1) mcount++;
            n.valid = v && !fl && !e.stall;
            n.we = n.valid && we; n.is_load = n.valid && ld; n.waddr = n.valid ? wa : 0;
            pipe.push_front(n);
            void'(pipe.pop_back());
        end
        cyc++;
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so each driven cycle presents a result at negedge.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("stall",       stall,       e.stall);
            chk("rs_fwd_sel",  rs_fwd_sel,  e.rs_sel);
            chk("rt_fwd_sel",  rt_fwd_sel,  e.rt_sel);
            chk("rs_data",     rs_data,     e.rs_d);
            chk("rt_data",     rt_data,     e.rt_d);
            chk("stall_count", stall_count, e.cnt);
        end
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with a would-be reader present.
        step(1,0,0, 1,3, 1,4, 1,3,0, 1);
        // ALU chain: add $3 then read $3 from EX.
        step(1,0,0, 0,0, 0,0, 1,3,0, 0);
        step(1,0,0, 1,3, 0,0, 0,0,0, 0);
        // Load-use on rt: one stall, then forward from MEM.
        step(1,0,0, 0,0, 0,0, 1,5,1, 0);
        step(1,0,0, 0,0, 1,5, 0,0,0, 0);
        step(1,0,0, 0,0, 1,5, 0,0,0, 0);
        // Youngest wins: $7 in slot2 and slot0.
        step(1,0,0, 0,0, 0,0, 1,7,0, 0);
        step(0,0,0, 0,0, 0,0, 0,0,0, 0);
        step(1,0,0, 0,0, 0,0, 1,7,0, 0);
        step(1,0,0, 1,7, 1,7, 0,0,0, 0);
        // Zero register is never forwarded.
        step(1,0,0, 0,0, 0,0, 1,0,1, 0);
        step(1,0,0, 1,0, 1,0, 0,0,0, 0);
        // Hold during load-use: frozen three cycles, then one counted stall, then forward.
        step(1,0,0, 0,0, 0,0, 1,6,1, 0);
        repeat (3) step(1,0,1, 1,6, 0,0, 0,0,0, 0);
        step(1,0,0, 1,6, 0,0, 0,0,0, 0);
        step(1,0,0, 1,6, 0,0, 0,0,0, 0);
        // Flush beats the hazard; the following read sees MEM and no stall.
        step(1,0,0, 0,0, 0,0, 1,8,1, 0);
        step(1,1,0, 1,8, 1,8, 0,0,0, 0);
        step(1,0,0, 1,8, 0,0, 0,0,0, 0);
        // Mid-cycle reset while stalled under hold.
        step(1,0,0, 0,0, 0,0, 1,9,1, 0);
        step(1,0,1, 0,0, 1,9, 0,0,0, 0);
        step(1,0,1, 0,0, 1,9, 0,0,0, 1);
        step(1,0,0, 0,0, 1,9, 0,0,0, 0);
        // Drive the counter into saturation.
        for (int i = 0; i < 20; i++) begin
            step(1,0,0, 0,0, 0,0, 1,10,1, 0);
            step(1,0,0, 1,10, 0,0, 0,0,0, 0);
        end
        // Randomized traffic on a small register set to force collisions.
        rst = 0;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0,9) != 0, $urandom_range(0,9) == 0, $urandom_range(0,7) == 0,
                 $urandom_range(0,1), $urandom_range(0,3),
                 $urandom_range(0,1), $urandom_range(0,3),
                 $urandom_range(0,3) != 0, $urandom_range(0,3), $urandom_range(0,1),
                 $urandom_range(0,99) == 0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending, expected 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
